mem_slot_arbiter: RTL

- Time-division memory scheduler sharing one RAM/ROM address bus between the CPU and the video fetcher.
- Runs a fixed 4-state slot wheel on mem_phi: a video address slot, a video data slot, a CPU address slot and a CPU data slot.
- Drives mem_adr, RAM write strobe/data and RAM/ROM read-data selection, and returns data to each requester with a one-cycle ack.
- Generates the cpu_phi/vid_phi phase strobes that clock-enable the CPU core and the video engine.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_rd_mux.sv | 13 +
 rtl/mem_slot_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU/video memory slot arbiter.
package mem_pkg;

  localparam logic [15:0] ROM_BASE_DFLT = 16'hB000;

  typedef enum logic [1:0] {S_VA, S_VD, S_CA, S_CD} slot_state_t;

  typedef enum logic [1:0] {OwnIdle, OwnVid, OwnCpu} slot_owner_t;

  // Addresses at or above the ROM base decode to ROM.
  function automatic logic is_rom(input logic [15:0] adr, input logic [15:0] base);
    return adr >= base;
  endfunction

endpackage

// File: rtl/mem_rd_mux.sv
// RAM/ROM read-data select, driven by the region bit latched at slot issue.
module mem_rd_mux #(
  parameter int unsigned DAT_W = 8
) (
  input  logic             rom_sel,
  input  logic [DAT_W-1:0] ram_dat,
  input  logic [DAT_W-1:0] rom_dat,
  output logic [DAT_W-1:0] rd_dat
);

  assign rd_dat = rom_sel ? rom_dat : ram_dat;

endmodule

// File: rtl/mem_slot_arbiter.sv
// Four-slot time-division scheduler sharing one memory bus between CPU and video.
// Define MEM_SLOT_STEAL_EN to let the CPU take the video slot pair when video is idle.
module mem_slot_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned      ADR_W    = 16,
  parameter int unsigned      DAT_W    = 8,
  parameter logic [ADR_W-1:0] ROM_BASE = ROM_BASE_DFLT
) (
  input  logic             mem_phi,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [DAT_W-1:0] cpu_dbo,
  output logic             cpu_ack,
  output logic [DAT_W-1:0] cpu_dbi,
  input  logic             vid_req,
  input  logic [ADR_W-1:0] vid_adr,
  output logic             vid_ack,
  output logic [DAT_W-1:0] vid_dbi,
  output logic [ADR_W-1:0] mem_adr,
  output logic [DAT_W-1:0] mem_dbo,
  output logic             ram_we,
  input  logic [DAT_W-1:0] ram_dbo,
  input  logic [DAT_W-1:0] rom_dbo,
  output logic             cpu_phi,
  output logic             vid_phi,
  output logic             rom_wr_err
);

  slot_state_t state_q, state_d;
  slot_owner_t own_q, own_d;
  logic             wr_q, wr_d;
  logic             rom_q, rom_d;
  logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
  logic [DAT_W-1:0] mem_dbo_q, mem_dbo_d;
  logic [DAT_W-1:0] cpu_dbi_q, cpu_dbi_d;
  logic [DAT_W-1:0] vid_dbi_q, vid_dbi_d;
  logic             ram_we_q, ram_we_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             vid_ack_q, vid_ack_d;
  logic             rom_wr_err_q, rom_wr_err_d;
  logic             cpu_issue, vid_issue;
  logic [DAT_W-1:0] rd_dat;

  mem_rd_mux #(
    .DAT_W(DAT_W)
  ) u_rd_mux (
    .rom_sel(rom_q),
    .ram_dat(ram_dbo),
    .rom_dat(rom_dbo),
    .rd_dat (rd_dat)
  );

  // State register
  always_ff @(posedge mem_phi or posedge rst) begin
    if (rst) state_q <= S_VA;
    else     state_q <= state_d;
  end

  // Next state: the wheel advances unconditionally
  always_comb begin
    state_d = S_VA;
    unique case (state_q)
      S_VA:    state_d = S_VD;
      S_VD:    state_d = S_CA;
      S_CA:    state_d = S_CD;
      S_CD:    state_d = S_VA;
      default: state_d = S_VA;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    vid_phi = (state_q == S_VD);
    cpu_phi = (state_q == S_CD);
  end

  // Every edge leaving a data slot both retires the current owner and issues the next slot.
  always_comb begin
    own_d        = own_q;
    wr_d         = wr_q;
    rom_d        = rom_q;
    mem_adr_d    = mem_adr_q;
    mem_dbo_d    = mem_dbo_q;
    cpu_dbi_d    = cpu_dbi_q;
    vid_dbi_d    = vid_dbi_q;
    ram_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;
    rom_wr_err_d = 1'b0;
    cpu_issue    = 1'b0;
    vid_issue    = 1'b0;
    if (state_q == S_VD || state_q == S_CD) begin
      case (own_q)
        OwnVid: begin
          vid_ack_d = 1'b1;
          vid_dbi_d = rd_dat;
        end
        OwnCpu: begin
          cpu_ack_d = 1'b1;
          if (!wr_q) cpu_dbi_d = rd_dat;
          else       rom_wr_err_d = rom_q;
        end
        default: ;
      endcase
      own_d = OwnIdle;
      if (state_q == S_CD) begin
        if (vid_req) vid_issue = 1'b1;
`ifdef MEM_SLOT_STEAL_EN
        else if (cpu_req) cpu_issue = 1'b1;
`endif
      end else begin
        // A stolen CPU access retiring on this edge still counts as in flight.
        cpu_issue = cpu_req && (own_q != OwnCpu);
      end
      if (vid_issue) begin
        own_d     = OwnVid;
        wr_d      = 1'b0;
        rom_d     = is_rom(vid_adr, ROM_BASE);
        mem_adr_d = vid_adr;
      end else if (cpu_issue) begin
        own_d     = OwnCpu;
        wr_d      = cpu_we;
        rom_d     = is_rom(cpu_adr, ROM_BASE);
        mem_adr_d = cpu_adr;
        if (cpu_we && !is_rom(cpu_adr, ROM_BASE)) begin
          ram_we_d  = 1'b1;
          mem_dbo_d = cpu_dbo;
        end
      end
    end
  end

  always_ff @(posedge mem_phi or posedge rst) begin
    if (rst) begin
      own_q        <= OwnIdle;
      wr_q         <= 1'b0;
      rom_q        <= 1'b0;
      mem_adr_q    <= '0;
      mem_dbo_q    <= '0;
      cpu_dbi_q    <= '0;
      vid_dbi_q    <= '0;
      ram_we_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      vid_ack_q    <= 1'b0;
      rom_wr_err_q <= 1'b0;
    end else begin
      own_q        <= own_d;
      wr_q         <= wr_d;
      rom_q        <= rom_d;
      mem_adr_q    <= mem_adr_d;
      mem_dbo_q    <= mem_dbo_d;
      cpu_dbi_q    <= cpu_dbi_d;
      vid_dbi_q    <= vid_dbi_d;
      ram_we_q     <= ram_we_d;
      cpu_ack_q    <= cpu_ack_d;
      vid_ack_q    <= vid_ack_d;
      rom_wr_err_q <= rom_wr_err_d;
    end
  end

  assign mem_adr    = mem_adr_q;
  assign mem_dbo    = mem_dbo_q;
  assign cpu_dbi    = cpu_dbi_q;
  assign vid_dbi    = vid_dbi_q;
  assign ram_we     = ram_we_q;
  assign cpu_ack    = cpu_ack_q;
  assign vid_ack    = vid_ack_q;
  assign rom_wr_err = rom_wr_err_q;

endmodule
